// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side sequencer between the TX FIFO and the pad.
// Pops one word per frame from a show-ahead FIFO and serialises it as
// start bit, DATA_BITS data bits LSB-first, optional parity bit and
// STOP_BITS stop bits. tx and busy are registered outputs. fifo_pop is
// combinational so that the word is captured in the same cycle it is popped.
// rst_n is an asynchronous reset that is active-high, despite its name.
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_en,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_rd_data,
   output logic                 fifo_pop,
   output logic                 tx,
   output logic                 busy
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   // The bit counter is reused to count stop bits.
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic              ODD_SEL   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state_q,  state_d;
   logic [BAUD_W-1:0]     baud_q,   baud_d;
   logic [BIT_W-1:0]      bit_q,    bit_d;
   logic [DATA_BITS-1:0]  shift_q,  shift_d;
   logic                  parity_q, parity_d;
   logic                  tx_q,     tx_d;
   logic                  busy_q,   busy_d;

   logic bit_end;
   logic pop_ok;
   logic pop_start;

   // Frame sequencing: next state, counters, word capture and registered outputs.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      pop_start = 1'b0;
      bit_end   = (baud_q == BAUD_LAST);
      pop_ok    = tx_en && !fifo_empty;

      case (state_q)
         S_IDLE: begin
            if (pop_ok) begin
               pop_start = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               baud_d  = '0;
               bit_d   = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               baud_d  = '0;
               bit_d   = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  // Chain straight into the next frame when a word is waiting.
                  if (pop_ok) begin
                     pop_start = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      // Capture the head word in the pop cycle; parity is taken from the whole word.
      if (pop_start) begin
         state_d  = S_START;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = fifo_rd_data;
         parity_d = (^fifo_rd_data) ^ ODD_SEL;
      end

      // Outputs are registered, so they follow the state being entered.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers with immediate reset to the idle line state.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   // The pop strobe is suppressed for as long as reset is held.
   assign fifo_pop = pop_start & ~rst_n;
   assign tx       = tx_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: bench for uart_tx_ctrl with CLKS_PER_BIT=4, DATA_BITS=8.
// One main instance (no parity, one stop bit) fed by a queue-model FIFO, and
// three single-word instances covering even/odd parity and two stop bits.
// Words expected on the line are queued when pushed into the FIFO and popped
// by a frame receiver that decodes the main tx line.
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_en;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data;
   logic       fifo_pop;
   logic       tx;
   logic       busy;

   logic [2:0] p_empty;
   logic [2:0] p_pop;
   logic [2:0] p_tx;
   logic [2:0] p_busy;
   logic [7:0] par_word = 8'h07;

   logic [7:0] q0[$];
   logic [7:0] exp_q[$];

   int checks = 0;
   int errors = 0;
   int pop_violation = 0;

   // Values sampled on the falling edge by tick()
   logic       s_pop, s_tx, s_busy;
   logic [2:0] s_ppop, s_ptx, s_pbusy;

   // Frame receiver state
   logic       rx_active = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_word = '0;

   logic txh   [128];
   logic busyh [128];
   logic poph  [128];
   logic p_txh   [3][64];
   logic p_busyh [3][64];
   logic p_poph  [3][64];

   typedef struct packed {
      logic [7:0] data;
      logic [9:0] frame;   // bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop
   } vec_t;

   typedef struct packed {
      logic       par;
      logic [7:0] frame_len;
      logic [7:0] stop_len;
   } pvec_t;

   vec_t  vecs  [4];
   pvec_t pvecs [3];

   always #5 clk = ~clk;

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_pop(fifo_pop), .tx(tx), .busy(busy));

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_par_even (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(p_empty[0]),
      .fifo_rd_data(par_word), .fifo_pop(p_pop[0]), .tx(p_tx[0]), .busy(p_busy[0]));

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_par_odd (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(p_empty[1]),
      .fifo_rd_data(par_word), .fifo_pop(p_pop[1]), .tx(p_tx[1]), .busy(p_busy[1]));

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_par_even2 (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(p_empty[2]),
      .fifo_rd_data(par_word), .fifo_pop(p_pop[2]), .tx(p_tx[2]), .busy(p_busy[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic refresh();
      fifo_empty   = (q0.size() == 0);
      fifo_rd_data = (q0.size() == 0) ? 8'h00 : q0[0];
   endtask

   // Decodes the main tx line (40-cycle frames) and checks against the scoreboard.
   task automatic monitor(input logic line);
      logic [7:0] exp_w;
      if (rst_n) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (!line) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
            rx_word   = '0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == 2) chk("rx_start_bit", line, 1'b0);
         if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0)
            rx_word[(rx_cnt - 6) / 4] = line;
         if (rx_cnt == 38) begin
            chk("rx_stop_bit", line, 1'b1);
            if (exp_q.size() == 0) begin
               chk("rx_unexpected_frame", 32'(rx_word), 32'hFFFF_FFFF);
            end else begin
               exp_w = exp_q.pop_front();
               chk("rx_word", rx_word, exp_w);
               $display("frame received %02h expected %02h", rx_word, exp_w);
            end
         end
         if (rx_cnt == 39) rx_active = 1'b0;
      end
   endtask

   // One clock: sample at the falling edge, then update the FIFO models after the rising edge.
   task automatic tick();
      @(negedge clk);
      s_pop   = fifo_pop;
      s_tx    = tx;
      s_busy  = busy;
      s_ppop  = p_pop;
      s_ptx   = p_tx;
      s_pbusy = p_busy;
      if (fifo_pop && fifo_empty) pop_violation++;
      for (int i = 0; i < 3; i++)
         if (p_pop[i] && p_empty[i]) pop_violation++;
      monitor(s_tx);
      @(posedge clk);
      #1;
      if (s_pop && q0.size() > 0) void'(q0.pop_front());
      for (int i = 0; i < 3; i++)
         if (s_ppop[i]) p_empty[i] = 1'b1;
      refresh();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       got;
      logic [9:0] frm;
      logic [7:0] w;
      int         npop, nbusy, nbad;

      vecs[0] = '{data: 8'hA5, frame: 10'h34A};
      vecs[1] = '{data: 8'h00, frame: 10'h200};
      vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
      vecs[3] = '{data: 8'h3C, frame: 10'h278};
      pvecs[0] = '{par: 1'b1, frame_len: 8'd44, stop_len: 8'd4};
      pvecs[1] = '{par: 1'b0, frame_len: 8'd44, stop_len: 8'd4};
      pvecs[2] = '{par: 1'b1, frame_len: 8'd48, stop_len: 8'd8};

      rst_n   = 1'b1;
      tx_en   = 1'b0;
      p_empty = 3'b111;
      refresh();

      // Reset state
      for (int k = 0; k < 3; k++) tick();
      chk("reset_tx", s_tx, 1'b1);
      chk("reset_busy", s_busy, 1'b0);
      chk("reset_pop", s_pop, 1'b0);
      rst_n = 1'b0;
      tick();

      // Single words, cycle-exact against the table
      for (int v = 0; v < 4; v++) begin
         q0.push_back(vecs[v].data);
         exp_q.push_back(vecs[v].data);
         refresh();
         tx_en = 1'b1;
         got = 1'b0;
         for (int n = 0; n < 8 && !got; n++) begin
            tick();
            got = s_pop;
         end
         chk("t1_pop_seen", got, 1'b1);
         frm  = vecs[v].frame;
         npop = 0;
         for (int k = 0; k < 40; k++) begin
            tick();
            chk("t1_tx_bit", s_tx, frm[k / 4]);
            chk("t1_busy", s_busy, 1'b1);
            if (s_pop) npop++;
         end
         chk("t1_single_pop", npop, 0);
         tick();
         chk("t1_idle_tx", s_tx, 1'b1);
         chk("t1_idle_busy", s_busy, 1'b0);
         $display("vector %0d data %02h done", v, vecs[v].data);
      end

      // Back-to-back frames
      q0.push_back(8'h55);
      q0.push_back(8'h0F);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h0F);
      refresh();
      npop = 0;
      nbusy = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         txh[k] = s_tx;
         busyh[k] = s_busy;
         poph[k] = s_pop;
         if (s_pop) npop++;
         if (s_busy) nbusy++;
      end
      chk("t2_pop_count", npop, 2);
      chk("t2_first_pop", poph[0], 1'b1);
      chk("t2_second_pop_at_40", poph[40], 1'b1);
      chk("t2_last_stop", txh[40], 1'b1);
      chk("t2_next_start", txh[41], 1'b0);
      chk("t2_busy_join", busyh[41], 1'b1);
      chk("t2_busy_cycles", nbusy, 80);
      chk("t2_busy_end", busyh[81], 1'b0);

      // Parity and stop-bit variants, all sending 0x07
      p_empty = 3'b000;
      for (int k = 0; k < 60; k++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            p_txh[i][k]   = s_ptx[i];
            p_busyh[i][k] = s_pbusy[i];
            p_poph[i][k]  = s_ppop[i];
         end
      end
      for (int i = 0; i < 3; i++) begin
         npop = 0;
         nbusy = 0;
         for (int k = 0; k < 60; k++) begin
            if (p_poph[i][k]) npop++;
            if (p_busyh[i][k]) nbusy++;
         end
         for (int b = 0; b < 8; b++) w[b] = p_txh[i][7 + 4 * b];
         chk("t3_pops", npop, 1);
         chk("t3_frame_len", nbusy, pvecs[i].frame_len);
         chk("t3_start", p_txh[i][3], 1'b0);
         chk("t3_data", w, 8'h07);
         chk("t3_parity", p_txh[i][38], pvecs[i].par);
         chk("t3_last_stop_tx", p_txh[i][40 + int'(pvecs[i].stop_len)], 1'b1);
         chk("t3_last_stop_busy", p_busyh[i][40 + int'(pvecs[i].stop_len)], 1'b1);
         chk("t3_after_stop_busy", p_busyh[i][41 + int'(pvecs[i].stop_len)], 1'b0);
         $display("parity variant %0d parity bit %0d frame %0d cycles", i, p_txh[i][38], nbusy);
      end

      // Enable gating
      tx_en = 1'b0;
      q0.push_back(8'hC3);
      q0.push_back(8'h81);
      exp_q.push_back(8'hC3);
      refresh();
      npop = 0;
      nbad = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (s_pop) npop++;
         if (s_tx !== 1'b1 || s_busy !== 1'b0) nbad++;
      end
      chk("t4_gated_pops", npop, 0);
      chk("t4_gated_idle", nbad, 0);
      tx_en = 1'b1;
      tick();
      chk("t4_pop_on_enable", s_pop, 1'b1);
      tick();
      chk("t4_start_next_cycle", s_tx, 1'b0);
      npop = 0;
      for (int k = 2; k <= 60; k++) begin
         tick();
         txh[k] = s_tx;
         busyh[k] = s_busy;
         if (s_pop) npop++;
         if (k == 18) tx_en = 1'b0;
      end
      chk("t4_no_more_pops", npop, 0);
      chk("t4_stop_tx", txh[39], 1'b1);
      chk("t4_stop_busy", busyh[40], 1'b1);
      chk("t4_idle_after", busyh[41], 1'b0);

      // Reset mid-frame (word 0x81 is sent and then truncated)
      tx_en = 1'b1;
      tick();
      chk("t5_pop", s_pop, 1'b1);
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (k == 10) begin
            q0.push_back(8'h97);
            exp_q.push_back(8'h97);
            refresh();
         end
      end
      rst_n = 1'b1;
      #1;
      chk("t5_async_tx", tx, 1'b1);
      chk("t5_async_busy", busy, 1'b0);
      chk("t5_pop_in_reset", fifo_pop, 1'b0);
      nbad = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (s_pop !== 1'b0 || s_tx !== 1'b1 || s_busy !== 1'b0) nbad++;
      end
      chk("t5_held_reset", nbad, 0);
      rst_n = 1'b0;
      tick();
      chk("t5_pop_after_release", s_pop, 1'b1);
      nbad = 0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         txh[k] = s_tx;
         if (k <= 4 && s_tx !== 1'b0) nbad++;
      end
      chk("t5_start_low", nbad, 0);
      chk("t5_start_len", txh[5], 1'b1);
      for (int k = 6; k <= 45; k++) tick();

      // Empty protection
      tx_en = 1'b1;
      npop = 0;
      nbad = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (s_pop) npop++;
         if (s_tx !== 1'b1 || s_busy !== 1'b0) nbad++;
      end
      chk("t6_no_pop", npop, 0);
      chk("t6_idle", nbad, 0);

      chk("scoreboard_drained", exp_q.size(), 0);
      chk("pop_while_empty", pop_violation, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side sequencer for the UART.
- Drains the TX FIFO (show-ahead read data, push/pop/empty/full interface) and serialises each word onto the tx line as a standard asynchronous frame: start, data LSB-first, optional parity, stop.
- Owns the FIFO pop strobe, baud-rate timing and frame state machine.
- Sits between the TX FIFO and the pad.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200). Legal range is 2 or greater.
- DATA_BITS, 8: data bits per frame, 5..9. Must equal the FIFO width.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock. All logic is rising-edge.
- rst_n  input  1  asynchronous, active-high reset.
- tx_en  input  1  transmit enable. Gates only the start of new frames.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_BITS  FIFO head word, valid combinationally while not empty.
- fifo_pop  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line, idles high, registered.
- busy  output  1  high while a frame is in progress, registered.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; tx=1, busy=0.
  - Baud counter, bit counter and shift register clear to 0.
  - fifo_pop=0 while reset is asserted.
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition:
  - fifo_pop is combinational: high when (state==IDLE, or last cycle of STOP) AND tx_en AND !fifo_empty.
  - It is high for exactly one cycle per frame.
  - It is never high when fifo_empty=1.
- On a pop cycle, the shift register captures fifo_rd_data and the state becomes START on the next edge.
- Latency: tx falls on the clk edge immediately after the pop cycle.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - Terminal count ends the current bit.
  - Resets to 0 on every state change.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shift register bit 0.
  - The shift register shifts right at each bit end.
  - Bit counter (width $clog2(DATA_BITS)) counts 0..DATA_BITS-1.
  - After the last bit: PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = XOR of the captured data word, inverted when PARITY_ODD=1. Duration one bit time, then STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last cycle: if the pop condition holds, go directly to START (no idle gap); otherwise go to IDLE.
- Frame length: F = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles. Back-to-back frames start exactly F cycles apart.
- busy=1 from the first START cycle to the last STOP cycle inclusive. It stays high across back-to-back frames.
- tx_en deasserted mid-frame: the current frame completes unchanged and no further pop occurs. tx_en has no effect on a frame in progress.
- fifo_empty rising mid-frame: no effect on the current frame, since data is already captured.
- Reset mid-frame: the frame is truncated and tx=1 immediately. The popped word is lost; no re-pop and no retry. After release, the next frame starts with a full-length START bit.
- The controller never drives FIFO push and ignores FIFO full.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8 unless stated.
1. Single word: FIFO holds 0xA5, tx_en=1, no parity.
   - Exactly one fifo_pop.
   - tx sequence, each bit 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 1.
   - busy high for 40 cycles, then tx=1, busy=0.
2. Back-to-back: FIFO holds 0x55 then 0x0F.
   - Two pops exactly 40 cycles apart.
   - The second start bit immediately follows the first stop bit with no idle cycle.
   - busy stays high for 80 cycles.
   - No third pop once fifo_empty=1.
3. Parity with data 0x07:
   - PARITY_EN=1, PARITY_ODD=0: parity bit is 1.
   - PARITY_ODD=1: parity bit is 0.
   - Frame is 44 cycles.
   - STOP_BITS=2: stop high for 8 cycles, frame 48 cycles.
4. Enable gating:
   - tx_en=0 with a non-empty FIFO: no pop, tx=1 for 100 cycles.
   - Raise tx_en: pop in that cycle, tx low the next cycle.
   - Drop tx_en during data bit 3: frame finishes intact, no further pop.
5. Reset mid-frame:
   - Assert rst_n during data bit 4: tx=1 and busy=0 without waiting for a clk edge; fifo_pop=0.
   - After release with FIFO non-empty: a new pop, and a start bit of the full 4 cycles.
6. Empty protection: FIFO empty throughout, tx_en=1 for 200 cycles → fifo_pop never asserted, tx=1, busy=0.
